ram_port_dma: RTL and testbench

- Initiator engine that drives one port of the dual-port word RAM (`p2_ram` A or B side), using that port's valid/byte-write/address/data protocol with 1-cycle read latency.
- Supports three modes:
  - copy: block copy from a source range to a destination range.
  - fill: pattern fill of a destination range.
  - check: compare a source range against a pattern.
- Used by testbench and boot logic to initialise or scrub memory while the core owns the other port.

---
 rtl/ram_port_dma.sv | 203 ++++++++++++++++++++
 tb/tb_ram_port_dma.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_dma.sv
// ram_port_dma: RAM-port initiator performing block copy, pattern fill and pattern check
// over one side of a dual-port word RAM with a 1-cycle read latency.
module ram_port_dma #(
   parameter int AW = 14
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          start_i,
   input  logic [1:0]    mode_i,
   input  logic [AW-1:0] src_addr_i,
   input  logic [AW-1:0] dst_addr_i,
   input  logic [AW:0]   len_i,
   input  logic [31:0]   pattern_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [AW:0]   err_cnt_o,
   output logic [AW-1:0] first_err_addr_o,
   output logic [AW-1:0] ram_addr_o,
   output logic          ram_valid_o,
   output logic [3:0]    ram_we_o,
   output logic [31:0]   ram_wdata_o,
   input  logic [31:0]   ram_rdata_i
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      COPY_RD  = 3'd1,
      COPY_WR  = 3'd2,
      FILL     = 3'd3,
      CHK_RD   = 3'd4,
      CHK_TAIL = 3'd5,
      DONE     = 3'd6
   } state_e;

   state_e        state_r;
   state_e        state_s;
   logic [AW-1:0] src_r;
   logic [AW-1:0] dst_r;
   logic [AW:0]   len_r;
   logic [31:0]   pat_r;
   logic [AW:0]   idx_r;
   logic [AW:0]   err_cnt_r;
   logic [AW-1:0] first_err_r;
   logic          chk_pend_r;
   logic [AW-1:0] chk_addr_r;
   logic          busy_r;
   logic          done_r;

   logic          start_s;
   logic [AW:0]   idx_inc_s;
   logic          last_s;
   logic [AW-1:0] src_a_s;
   logic [AW-1:0] dst_a_s;
   logic          mismatch_s;
   logic [AW-1:0] ram_addr_s;
   logic          ram_valid_s;
   logic [3:0]    ram_we_s;
   logic [31:0]   ram_wdata_s;

   assign start_s    = (state_r == IDLE) && start_i;
   assign idx_inc_s  = idx_r + {{AW{1'b0}}, 1'b1};
   assign last_s     = (idx_inc_s == len_r);
   // Word addresses wrap modulo 2^AW by truncation.
   assign src_a_s    = src_r + idx_r[AW-1:0];
   assign dst_a_s    = dst_r + idx_r[AW-1:0];
   assign mismatch_s = chk_pend_r && (ram_rdata_i != pat_r);

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_i) begin
               if ((len_i == {(AW+1){1'b0}}) || (mode_i == 2'd3)) begin
                  state_s = DONE;
               end else begin
                  case (mode_i)
                     2'd0:    state_s = COPY_RD;
                     2'd1:    state_s = FILL;
                     default: state_s = CHK_RD;
                  endcase
               end
            end else begin
               state_s = IDLE;
            end
         end
         COPY_RD:  state_s = COPY_WR;
         COPY_WR:  state_s = last_s ? DONE : COPY_RD;
         FILL:     state_s = last_s ? DONE : FILL;
         CHK_RD:   state_s = last_s ? CHK_TAIL : CHK_RD;
         CHK_TAIL: state_s = DONE;
         DONE:     state_s = IDLE;
         default:  state_s = IDLE;
      endcase
   end

   // RAM strobe generation; write data in COPY_WR is the word returned by the preceding read.
   always_comb begin
      ram_addr_s  = {AW{1'b0}};
      ram_valid_s = 1'b0;
      ram_we_s    = 4'h0;
      ram_wdata_s = 32'h0;
      case (state_r)
         COPY_RD: begin
            ram_valid_s = 1'b1;
            ram_addr_s  = src_a_s;
         end
         COPY_WR: begin
            ram_valid_s = 1'b1;
            ram_we_s    = 4'hF;
            ram_addr_s  = dst_a_s;
            ram_wdata_s = ram_rdata_i;
         end
         FILL: begin
            ram_valid_s = 1'b1;
            ram_we_s    = 4'hF;
            ram_addr_s  = dst_a_s;
            ram_wdata_s = pat_r;
         end
         CHK_RD: begin
            ram_valid_s = 1'b1;
            ram_addr_s  = src_a_s;
         end
         default: begin
            ram_valid_s = 1'b0;
         end
      endcase
   end

   // Operand capture, word index and check bookkeeping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         src_r       <= {AW{1'b0}};
         dst_r       <= {AW{1'b0}};
         len_r       <= {(AW+1){1'b0}};
         pat_r       <= 32'h0;
         idx_r       <= {(AW+1){1'b0}};
         err_cnt_r   <= {(AW+1){1'b0}};
         first_err_r <= {AW{1'b0}};
         chk_pend_r  <= 1'b0;
         chk_addr_r  <= {AW{1'b0}};
      end else begin
         chk_pend_r <= (state_r == CHK_RD);
         chk_addr_r <= src_a_s;
         if (start_s) begin
            src_r       <= src_addr_i;
            dst_r       <= dst_addr_i;
            len_r       <= len_i;
            pat_r       <= pattern_i;
            idx_r       <= {(AW+1){1'b0}};
            err_cnt_r   <= {(AW+1){1'b0}};
            first_err_r <= {AW{1'b0}};
         end else begin
            if ((state_r == COPY_WR) || (state_r == FILL) || (state_r == CHK_RD)) begin
               idx_r <= idx_inc_s;
            end else begin
               idx_r <= idx_r;
            end
            // The compare lags its read strobe by one cycle, so the address comes from chk_addr_r.
            if (mismatch_s) begin
               err_cnt_r <= err_cnt_r + {{AW{1'b0}}, 1'b1};
               if (err_cnt_r == {(AW+1){1'b0}}) begin
                  first_err_r <= chk_addr_r;
               end else begin
                  first_err_r <= first_err_r;
               end
            end else begin
               err_cnt_r <= err_cnt_r;
            end
         end
      end
   end

   // Status flags registered from the next state so they line up with state_r.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state_s != IDLE) && (state_s != DONE);
         done_r <= (state_s == DONE);
      end
   end

   assign busy_o           = busy_r;
   assign done_o           = done_r;
   assign err_cnt_o        = err_cnt_r;
   assign first_err_addr_o = first_err_r;
   assign ram_addr_o       = ram_addr_s;
   assign ram_valid_o      = ram_valid_s;
   assign ram_we_o         = ram_we_s;
   assign ram_wdata_o      = ram_wdata_s;

endmodule

// File: tb/tb_ram_port_dma.sv
// tb_ram_port_dma: directed stimulus with a queue-based scoreboard; the monitor pops expected
// RAM strobes and done pulses (with their cycle numbers) whenever the DUT presents one.
module tb_ram_port_dma;
   localparam int AW = 14;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic          rst_ni;
   logic          start_i;
   logic [1:0]    mode_i;
   logic [AW-1:0] src_addr_i, dst_addr_i;
   logic [AW:0]   len_i;
   logic [31:0]   pattern_i;
   logic          busy_o, done_o;
   logic [AW:0]   err_cnt_o;
   logic [AW-1:0] first_err_addr_o, ram_addr_o;
   logic          ram_valid_o;
   logic [3:0]    ram_we_o;
   logic [31:0]   ram_wdata_o, ram_rdata_i;

   logic          start4;
   logic [1:0]    mode4;
   logic [3:0]    src4, dst4, first4, addr4;
   logic [4:0]    len4, err4;
   logic [31:0]   pat4, wdata4, rdata4;
   logic          busy4, done4, valid4;
   logic [3:0]    we4;

   ram_port_dma #(.AW(AW)) u_dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
      .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i), .pattern_i(pattern_i),
      .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o), .first_err_addr_o(first_err_addr_o),
      .ram_addr_o(ram_addr_o), .ram_valid_o(ram_valid_o), .ram_we_o(ram_we_o),
      .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
   );

   ram_port_dma #(.AW(4)) u_dut4 (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start4), .mode_i(mode4),
      .src_addr_i(src4), .dst_addr_i(dst4), .len_i(len4), .pattern_i(pat4),
      .busy_o(busy4), .done_o(done4), .err_cnt_o(err4), .first_err_addr_o(first4),
      .ram_addr_o(addr4), .ram_valid_o(valid4), .ram_we_o(we4),
      .ram_wdata_o(wdata4), .ram_rdata_i(rdata4)
   );
   assign rdata4 = 32'h0;

   // RAM model with a backdoor write port for preloading
   logic [31:0]   mem [0:(1<<AW)-1];
   logic          bd_we;
   logic [AW-1:0] bd_addr;
   logic [31:0]   bd_data;
   int            cyc = 0;

   always @(posedge clk_i) begin
      cyc <= cyc + 1;
      if (bd_we) mem[bd_addr] <= bd_data;
      if (ram_valid_o) begin
         if (ram_we_o == 4'hF) mem[ram_addr_o] <= ram_wdata_o;
         else ram_rdata_i <= mem[ram_addr_o];
      end
   end

   typedef struct packed {
      logic          is_done;
      logic [31:0]   cyc;
      logic [AW-1:0] addr;
      logic [3:0]    we;
      logic [31:0]   wdata;
   } ev_t;
   typedef struct packed {
      logic [3:0]  addr;
      logic [3:0]  we;
      logic [31:0] wdata;
   } ev4_t;

   ev_t  exp_q[$];
   ev4_t exp4_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic void push_ev(logic d, int k, logic [AW-1:0] a, logic [3:0] w, logic [31:0] wd);
      ev_t e;
      e.is_done = d;
      e.cyc     = 32'(k);
      e.addr    = a;
      e.we      = w;
      e.wdata   = wd;
      exp_q.push_back(e);
   endfunction

   // Monitor: every strobe or done pulse must match the head of the expected queue
   initial begin
      ev_t  act, e;
      ev4_t act4, e4;
      forever begin
         @(negedge clk_i);
         if (ram_valid_o || done_o) begin
            act.is_done = done_o;
            act.cyc     = 32'(cyc);
            act.addr    = ram_addr_o;
            act.we      = ram_we_o;
            act.wdata   = ram_wdata_o;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_event: got done=%0b cyc=%0d addr=%h we=%h wd=%h, expected none",
                        act.is_done, act.cyc, act.addr, act.we, act.wdata);
            end else begin
               e = exp_q.pop_front();
               if (act !== e) begin
                  n_err++;
                  $display("FAIL event: got done=%0b cyc=%0d addr=%h we=%h wd=%h, expected done=%0b cyc=%0d addr=%h we=%h wd=%h",
                           act.is_done, act.cyc, act.addr, act.we, act.wdata,
                           e.is_done, e.cyc, e.addr, e.we, e.wdata);
               end
            end
         end
         if (valid4) begin
            act4 = {addr4, we4, wdata4};
            n_cmp++;
            if (exp4_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_wrap_strobe: got addr=%h we=%h wd=%h, expected none", addr4, we4, wdata4);
            end else begin
               e4 = exp4_q.pop_front();
               if (act4 !== e4) begin
                  n_err++;
                  $display("FAIL wrap_strobe: got %h expected %h", act4, e4);
               end
            end
         end
      end
   end

   task automatic check(string name, logic [63:0] act, logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic bd_write(int a, logic [31:0] d);
      @(negedge clk_i);
      bd_we   = 1'b1;
      bd_addr = AW'(a);
      bd_data = d;
      @(negedge clk_i);
      bd_we   = 1'b0;
   endtask

   task automatic set_args(logic [1:0] m, int s, int d, int l, logic [31:0] p);
      mode_i     = m;
      src_addr_i = AW'(s);
      dst_addr_i = AW'(d);
      len_i      = (AW+1)'(l);
      pattern_i  = p;
   endtask

   // Pulse start for one edge then scramble the arguments to prove they were captured
   task automatic pulse_start();
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      set_args(2'd1, 'h3333, 'h2222, 3, 32'h0BAD0BAD);
   endtask

   task automatic wait_done(string name);
      for (int i = 0; i < 300; i++) begin
         if (exp_q.size() == 0 && !busy_o && !done_o) break;
         @(negedge clk_i);
      end
      check({name, "_complete"}, 64'(exp_q.size()), 64'd0);
      @(negedge clk_i);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c;
      rst_ni = 1'b0;
      start_i = 1'b0;
      bd_we = 1'b0; bd_addr = '0; bd_data = 32'h0;
      start4 = 1'b0; mode4 = 2'd1; src4 = 4'h0; dst4 = 4'h0; len4 = 5'd0; pat4 = 32'h0;
      set_args(2'd0, 0, 0, 0, 32'h0);
      repeat (3) @(negedge clk_i);
      check("reset_outputs",
            64'({busy_o, done_o, err_cnt_o, first_err_addr_o, ram_valid_o, ram_we_o, ram_addr_o}), 64'd0);
      check("reset_wdata", 64'(ram_wdata_o), 64'd0);
      rst_ni = 1'b1;

      for (int i = 0; i < 4; i++) bd_write('h10 + i, 32'hA0 + 32'(i));
      for (int i = 0; i < 5; i++) bd_write('h203 + i, 32'h11111111);

      // Copy 0x10..0x13 -> 0x40..0x43, with a start pulse mid-transfer that must be ignored
      @(negedge clk_i);
      c = cyc;
      for (int i = 0; i < 4; i++) begin
         push_ev(1'b0, c + 2*i + 1, AW'('h10 + i), 4'h0, 32'h0);
         push_ev(1'b0, c + 2*i + 2, AW'('h40 + i), 4'hF, 32'hA0 + 32'(i));
      end
      push_ev(1'b1, c + 9, '0, 4'h0, 32'h0);
      set_args(2'd0, 'h10, 'h40, 4, 32'h0);
      pulse_start();
      for (int k = 1; k <= 10; k++) begin
         check($sformatf("copy_busy_c%0d", k), 64'(busy_o), (k <= 8) ? 64'd1 : 64'd0);
         if (k == 3) begin
            set_args(2'd1, 'h10, 'h500, 2, 32'h77777777);
            start_i = 1'b1;
         end else begin
            start_i = 1'b0;
         end
         @(negedge clk_i);
      end
      wait_done("copy");
      for (int i = 0; i < 4; i++)
         check($sformatf("copy_mem_%0d", i), 64'(mem['h40 + i]), 64'(32'hA0 + 32'(i)));

      // Fill 16 words, corrupt one, then check the range
      c = cyc;
      for (int i = 0; i < 16; i++) push_ev(1'b0, c + 1 + i, AW'('h100 + i), 4'hF, 32'hDEADBEEF);
      push_ev(1'b1, c + 17, '0, 4'h0, 32'h0);
      set_args(2'd1, 0, 'h100, 16, 32'hDEADBEEF);
      pulse_start();
      wait_done("fill");
      bd_write('h105, 32'h0);
      @(negedge clk_i);
      c = cyc;
      for (int i = 0; i < 16; i++) push_ev(1'b0, c + 1 + i, AW'('h100 + i), 4'h0, 32'h0);
      push_ev(1'b1, c + 18, '0, 4'h0, 32'h0);
      set_args(2'd2, 'h100, 0, 16, 32'hDEADBEEF);
      pulse_start();
      wait_done("check");
      check("check_err_cnt", 64'(err_cnt_o), 64'd1);
      check("check_first_err", 64'(first_err_addr_o), 64'h105);

      // Mismatch on the last word only, caught by the tail compare
      c = cyc;
      push_ev(1'b0, c + 1, AW'('h104), 4'h0, 32'h0);
      push_ev(1'b0, c + 2, AW'('h105), 4'h0, 32'h0);
      push_ev(1'b1, c + 4, '0, 4'h0, 32'h0);
      set_args(2'd2, 'h104, 0, 2, 32'hDEADBEEF);
      pulse_start();
      wait_done("check_tail");
      check("tail_err_cnt", 64'(err_cnt_o), 64'd1);
      check("tail_first_err", 64'(first_err_addr_o), 64'h105);

      // Wrap-around on the AW=4 instance
      for (int i = 0; i < 4; i++) exp4_q.push_back({4'(4'hE + i), 4'hF, 32'h5A5A5A5A});
      @(negedge clk_i);
      mode4 = 2'd1; dst4 = 4'hE; len4 = 5'd4; pat4 = 32'h5A5A5A5A;
      start4 = 1'b1;
      @(negedge clk_i);
      start4 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (exp4_q.size() == 0 && !busy4) break;
         @(negedge clk_i);
      end
      check("wrap_complete", 64'(exp4_q.size()), 64'd0);
      check("wrap_status", 64'({busy4, err4, first4}), 64'd0);

      // len=0 with start held into DONE (second edge must be ignored), then mode 3
      @(negedge clk_i);
      c = cyc;
      push_ev(1'b1, c + 1, '0, 4'h0, 32'h0);
      set_args(2'd0, 'h10, 'h40, 0, 32'h0);
      start_i = 1'b1;
      @(negedge clk_i);
      check("len0_done", 64'(done_o), 64'd1);
      @(negedge clk_i);
      start_i = 1'b0;
      wait_done("len0");
      check("len0_err_cleared", 64'({err_cnt_o, first_err_addr_o}), 64'd0);
      c = cyc;
      push_ev(1'b1, c + 1, '0, 4'h0, 32'h0);
      set_args(2'd3, 'h10, 'h40, 5, 32'h0);
      pulse_start();
      wait_done("mode3");
      check("mode3_err", 64'(err_cnt_o), 64'd0);

      // Reset after 3 of 8 fill writes
      c = cyc;
      for (int i = 0; i < 3; i++) push_ev(1'b0, c + 1 + i, AW'('h200 + i), 4'hF, 32'hCAFEF00D);
      set_args(2'd1, 0, 'h200, 8, 32'hCAFEF00D);
      pulse_start();
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b0;
      #1;
      check("rst_async_outputs",
            64'({busy_o, done_o, err_cnt_o, first_err_addr_o, ram_valid_o, ram_we_o, ram_addr_o}), 64'd0);
      check("rst_async_wdata", 64'(ram_wdata_o), 64'd0);
      repeat (3) @(negedge clk_i);
      check("rst_pending", 64'(exp_q.size()), 64'd0);
      for (int i = 0; i < 3; i++)
         check($sformatf("rst_mem_written_%0d", i), 64'(mem['h200 + i]), 64'(32'hCAFEF00D));
      for (int i = 3; i < 8; i++)
         check($sformatf("rst_mem_untouched_%0d", i), 64'(mem['h200 + i]), 64'(32'h11111111));
      rst_ni = 1'b1;
      @(negedge clk_i);
      c = cyc;
      push_ev(1'b0, c + 1, AW'('h200), 4'hF, 32'h12345678);
      push_ev(1'b0, c + 2, AW'('h201), 4'hF, 32'h12345678);
      push_ev(1'b1, c + 3, '0, 4'h0, 32'h0);
      set_args(2'd1, 0, 'h200, 2, 32'h12345678);
      pulse_start();
      wait_done("post_reset_fill");
      check("post_reset_mem", 64'(mem['h201]), 64'(32'h12345678));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
